// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester-side and transmitter-side handshake bundle for the UART TX arbiter
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      tx_valid;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_ready;

  // master: the surroundings (requesters + transmitter); slave: the arbiter
  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin burst arbiter sharing one UART transmitter
// A grant lasts until req_last or MAX_BURST bytes; each byte passes through one holding register.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  uart_tx_arbiter_if.slave           bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRIVE} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic                last_q, last_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic                tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                busy_q, busy_d;

  logic                found;
  logic [ID_W-1:0]     pick;
  logic [ID_W-1:0]     idx;
  logic [ID_W-1:0]     next_rr;
  logic [NUM_REQ-1:0]  one_hot_base;

  assign one_hot_base = {{(NUM_REQ-1){1'b0}}, 1'b1};
  assign next_rr = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);

  // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;
    last_d      = last_q;
    req_ready_d = req_ready_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_id_d  = pick;
          burst_cnt_d = '0;
          req_ready_d = one_hot_base << pick;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        req_ready_d = '0;
        if (bus.req_valid[grant_id_q]) begin
          tx_data_d   = bus.req_data[grant_id_q*DATA_W +: DATA_W];
          last_d      = bus.req_last[grant_id_q];
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
          tx_valid_d  = 1'b1;
          state_d     = DRIVE;
        end else begin
          rr_ptr_d = next_rr;
          state_d  = IDLE;
        end
      end
      DRIVE: begin
        if (bus.tx_ready) begin
          tx_valid_d = 1'b0;
          if (last_q || burst_cnt_q == CNT_W'(MAX_BURST)) begin
            rr_ptr_d = next_rr;
            state_d  = IDLE;
          end else begin
            req_ready_d = one_hot_base << grant_id_q;
            state_d     = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      burst_cnt_q <= '0;
      last_q      <= 1'b0;
      req_ready_q <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
      last_q      <= last_d;
      req_ready_q <= req_ready_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_data   = tx_data_q;
  assign grant_id      = grant_id_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] grant_id;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] txq[$];
  int         grant_cnt = 0;
  logic       busy_seen = 1'b0;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Transfers and grant starts, sampled half a cycle before the edge that commits them
  always @(negedge clk) begin
    if (bus.tx_valid && bus.tx_ready) txq.push_back(bus.tx_data);
    if (busy && !busy_seen) grant_cnt++;
    busy_seen = busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic [7:0] d, input logic l);
    bus.req_valid[r]       = v;
    bus.req_data[r*8 +: 8] = d;
    bus.req_last[r]        = l;
  endtask

  // Grant, accept and transmit one last-flagged byte of requester r (tx_ready=1, arbiter idle)
  task automatic serve_one(input int r, input logic [7:0] d);
    step();
    chk("serve_grant_id", grant_id, r);
    chk("serve_req_ready", bus.req_ready, 1 << r);
    chk("serve_busy", busy, 1);
    step();
    bus.req_valid[r] = 1'b0;
    chk("serve_req_ready_drop", bus.req_ready, 0);
    chk("serve_tx_valid", bus.tx_valid, 1);
    chk("serve_tx_data", bus.tx_data, d);
    step();
    chk("serve_tx_valid_drop", bus.tx_valid, 0);
    chk("serve_idle", busy, 0);
  endtask

  // Raise mask, check who wins, then abandon in FETCH so rr_ptr becomes winner+1
  task automatic probe(input logic [3:0] mask, input int exp_gid);
    bus.req_valid = mask;
    bus.req_last  = 4'hF;
    step();
    chk("probe_grant_id", grant_id, exp_gid);
    chk("probe_req_ready", bus.req_ready, 1 << exp_gid);
    bus.req_valid = '0;
    step();
    chk("probe_abandon_idle", busy, 0);
    chk("probe_no_tx", bus.tx_valid, 0);
  endtask

  task automatic send_bytes(input int r, input logic [7:0] first, input int n);
    logic seen;
    for (int k = 0; k < n; k++) begin
      set_req(r, 1'b1, first + 8'(k), (k == n - 1));
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        if (bus.req_ready[r]) seen = 1'b1;
        else step();
      end
      chk("send_ready_seen", seen, 1);
      if (!seen) begin
        bus.req_valid[r] = 1'b0;
        return;
      end
      step();
    end
    bus.req_valid[r] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk("wait_idle", busy, 0);
  endtask

  initial begin
    int tq0;
    int g0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_ready  = 1'b1;
    reset = 1'b0;
    repeat (3) step();
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    step();

    // Single byte from requester 1, then rr_ptr must sit at 2
    set_req(1, 1'b1, 8'hA5, 1'b1);
    serve_one(1, 8'hA5);
    chk("t1_tx_count", txq.size(), 1);
    chk("t1_tx_byte", txq[0], 8'hA5);
    probe(4'b0101, 2);

    // Requesters 0 and 2 together, twice, covering the pointer wrap
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    set_req(0, 1'b1, 8'h30, 1'b1);
    set_req(2, 1'b1, 8'h32, 1'b1);
    serve_one(0, 8'h30);
    serve_one(2, 8'h32);
    set_req(0, 1'b1, 8'h40, 1'b1);
    set_req(2, 1'b1, 8'h42, 1'b1);
    serve_one(0, 8'h40);
    serve_one(2, 8'h42);

    // Six-byte message split by MAX_BURST into two grants
    tq0 = txq.size();
    g0  = grant_cnt;
    send_bytes(3, 8'h10, 6);
    wait_idle();
    chk("t3_tx_count", txq.size() - tq0, 6);
    for (int k = 0; k < 6 && tq0 + k < txq.size(); k++)
      chk("t3_tx_byte", txq[tq0+k], 8'h10 + k);
    chk("t3_grant_count", grant_cnt - g0, 2);

    // Transmitter backpressure for 20 cycles with another requester waiting
    bus.tx_ready = 1'b0;
    set_req(1, 1'b1, 8'h77, 1'b1);
    set_req(2, 1'b1, 8'h88, 1'b1);
    step();
    chk("t4_grant_id", grant_id, 1);
    step();
    bus.req_valid[1] = 1'b0;
    chk("t4_tx_valid", bus.tx_valid, 1);
    chk("t4_tx_data", bus.tx_data, 8'h77);
    tq0 = txq.size();
    for (int k = 0; k < 20; k++) begin
      step();
      chk("t4_hold_valid", bus.tx_valid, 1);
      chk("t4_hold_data", bus.tx_data, 8'h77);
      chk("t4_hold_ready", bus.req_ready, 0);
    end
    chk("t4_no_transfer", txq.size(), tq0);
    bus.tx_ready = 1'b1;
    step();
    chk("t4_released", bus.tx_valid, 0);
    chk("t4_one_transfer", txq.size(), tq0 + 1);

    // Requester 2 abandons its grant in FETCH
    tq0 = txq.size();
    step();
    chk("t5_grant_id", grant_id, 2);
    chk("t5_req_ready", bus.req_ready, 4'b0100);
    bus.req_valid[2] = 1'b0;
    step();
    chk("t5_idle", busy, 0);
    chk("t5_req_ready_drop", bus.req_ready, 0);
    step();
    chk("t5_no_tx_valid", bus.tx_valid, 0);
    chk("t5_no_transfer", txq.size(), tq0);
    probe(4'b1100, 3);

    // Reset while 0x5A is held in DRIVE
    probe(4'b0010, 1);
    bus.tx_ready = 1'b0;
    set_req(3, 1'b1, 8'h5A, 1'b1);
    step();
    chk("t6_grant_id", grant_id, 3);
    step();
    bus.req_valid[3] = 1'b0;
    chk("t6_tx_valid", bus.tx_valid, 1);
    chk("t6_tx_data", bus.tx_data, 8'h5A);
    step();
    tq0 = txq.size();
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_tx_valid", bus.tx_valid, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_req_ready", bus.req_ready, 0);
    step();
    step();
    reset = 1'b1;
    bus.tx_ready = 1'b1;
    step();
    probe(4'b1111, 0);
    repeat (3) step();
    chk("t6_no_stale_tx", txq.size(), tq0);
    chk("t6_tx_valid_low", bus.tx_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
